// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg
// Shared definitions for the vectored interrupt controller.
//
// Contents:
//   irq_state_e   - controller FSM state encoding (IDLE / ASSERT / INSERVICE)
//   REG_*         - register select values seen on the 2-bit 'a' input
//   STAT_*        - bit positions of the fields packed into the STATUS register
//   ID_W          - width of a source index (up to 8 sources)
//   vec_addr()    - vector address of a source: base + id * stride, 32-bit wrap
// ----------------------------------------------------------------------------
package irq_pkg;

   // Source indices are always carried in 3 bits so up to 8 sources fit
   localparam int ID_W = 3;

   typedef enum logic [1:0] {
      IRQ_IDLE      = 2'd0,
      IRQ_ASSERT    = 2'd1,
      IRQ_INSERVICE = 2'd2
   } irq_state_e;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_EOI     = 2'd3;

   // STATUS register layout
   localparam int STAT_ID_LSB    = 0;
   localparam int STAT_ID_W      = 3;
   localparam int STAT_RR_LSB    = 4;
   localparam int STAT_RR_W      = 3;
   localparam int STAT_STATE_LSB = 8;
   localparam int STAT_STATE_W   = 2;

   // The product is truncated to 32 bits, so a large stride simply wraps
   function automatic logic [31:0] vec_addr(input logic [31:0]     base,
                                            input logic [31:0]     stride,
                                            input logic [ID_W-1:0] id);
      return base + (32'(id) * stride);
   endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// ----------------------------------------------------------------------------
// irq_prio_arb
// Combinational priority arbiter. Starting at index 'base' and walking upward
// (wrapping at N_SRC), the first set bit of 'req' wins. With base tied to 0
// this is a plain lowest-index-wins arbiter.
//
// Parameters:
//   N_SRC  - number of request lines (1..8)
// Ports:
//   req    in  [N_SRC-1:0]  request vector
//   base   in  [ID_W-1:0]   index searched first; must be below N_SRC
//   valid  out              at least one request is set
//   grant  out [ID_W-1:0]   index of the winning request (0 when !valid)
// ----------------------------------------------------------------------------
module irq_prio_arb
   import irq_pkg::*;
#(
   parameter int N_SRC = 4
) (
   input  logic [N_SRC-1:0] req,
   input  logic [ID_W-1:0]  base,
   output logic             valid,
   output logic [ID_W-1:0]  grant
);

   logic [N_SRC-1:0] rot;
   logic [ID_W:0]    sum;

   // Rotating the doubled request vector right by 'base' puts the search
   // start at bit 0, so a fixed lowest-bit scan implements the wrap-around.
   // The winning offset is then rotated back into an absolute index.
   always_comb begin
      rot   = N_SRC'({req, req} >> base);
      valid = 1'b0;
      grant = '0;
      sum   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         if (!valid && rot[k]) begin
            valid = 1'b1;
            sum   = {1'b0, base} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_SRC)) begin
               sum = sum - (ID_W+1)'(N_SRC);
            end
            grant = sum[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/irq_vector_ctrl.sv
// ----------------------------------------------------------------------------
// irq_vector_ctrl
// Vectored interrupt controller sitting between the factorial units' Done
// flags and the mips core's irq / irq_ack / irq_addr interface.
//
// Completion flags are edge detected and latched as pending, filtered by a
// software mask and arbitrated. The winner is presented to the core as a held
// irq with its vector address until acknowledged, after which the controller
// waits for an EOI write before it will raise the next interrupt.
//
// Optional build macro:
//   IRQ_ROUND_ROBIN_EN - rotating priority: arbitration starts at rr_ptr, which
//                        moves to the source after the one just acknowledged;
//                        rr_ptr is readable at STATUS[6:4]. Without the macro
//                        priority is fixed (lowest index wins).
//
// Parameters:
//   N_SRC       number of interrupt sources (1..8)
//   VEC_BASE    vector address of source 0
//   VEC_STRIDE  byte spacing between consecutive source vectors
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   src_done  in   [N_SRC-1:0] level completion flags
//   irq_ack   in   one-cycle acknowledge from the core
//   irq       out  interrupt request
//   irq_addr  out  [31:0] vector address of the granted source
//   we        in   register write strobe
//   a         in   [1:0] register select (PENDING, MASK, STATUS, EOI)
//   wd        in   [31:0] register write data
//   rd        out  [31:0] register read data (combinational)
// ----------------------------------------------------------------------------
module irq_vector_ctrl
   import irq_pkg::*;
#(
   parameter int          N_SRC      = 4,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] src_done,
   input  logic             irq_ack,
   output logic             irq,
   output logic [31:0]      irq_addr,
   input  logic             we,
   input  logic [1:0]       a,
   input  logic [31:0]      wd,
   output logic [31:0]      rd
);

   irq_state_e       state;
   logic [ID_W-1:0]  active_id;

   logic [N_SRC-1:0] done_q;
   logic [N_SRC-1:0] pending;
   logic [N_SRC-1:0] pending_nxt;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] rise;
   logic [N_SRC-1:0] ack_clr;
   logic [N_SRC-1:0] cand;

   logic             pend_wr;
   logic             mask_wr;
   logic             eoi_wr;
   logic             ack_take;

   logic             arb_valid;
   logic [ID_W-1:0]  arb_id;
   logic [ID_W-1:0]  arb_base;

   // Only the low N_SRC bits of wd carry register content
   logic             unused_wd;
   assign unused_wd = ^wd;

   // Register write decode and the handshake event that retires a request.
   // An acknowledge only counts while a request is actually being presented.
   always_comb begin
      pend_wr  = we && (a == REG_PENDING);
      mask_wr  = we && (a == REG_MASK);
      eoi_wr   = we && (a == REG_EOI);
      ack_take = (state == IRQ_ASSERT) && irq_ack;
      rise     = src_done & ~done_q;
      cand     = pending & mask;
   end

   // One-hot clear of the acknowledged source, built by comparison so the
   // 3-bit id never indexes past a narrower pending vector.
   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < N_SRC; i++) begin
         ack_clr[i] = ack_take && (active_id == ID_W'(i));
      end
   end

   // Pending update order matters: clears (software W1C and the acknowledge)
   // are applied first and new rising edges last, so a fresh event in the
   // same cycle as a clear is never lost.
   always_comb begin
      pending_nxt = pending;
      if (pend_wr) begin
         pending_nxt = pending_nxt & ~wd[N_SRC-1:0];
      end
      pending_nxt = pending_nxt & ~ack_clr;
      pending_nxt = pending_nxt | rise;
   end

   // Edge-detect history, pending latch and the software mask. The mask
   // resets to all ones so every source is enabled out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q  <= '0;
         pending <= '0;
         mask    <= '1;
      end else begin
         done_q  <= src_done;
         pending <= pending_nxt;
         if (mask_wr) begin
            mask <= wd[N_SRC-1:0];
         end
      end
   end

`ifdef IRQ_ROUND_ROBIN_EN
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W:0]   id_inc;
   logic [ID_W-1:0] rr_next;

   // Next search start is the source just after the one being acknowledged
   always_comb begin
      id_inc  = {1'b0, active_id} + (ID_W+1)'(1);
      rr_next = (id_inc >= (ID_W+1)'(N_SRC)) ? '0 : id_inc[ID_W-1:0];
   end

   assign arb_base = rr_ptr;
`else
   assign arb_base = '0;
`endif

   irq_prio_arb #(
      .N_SRC (N_SRC)
   ) u_arb (
      .req   (cand),
      .base  (arb_base),
      .valid (arb_valid),
      .grant (arb_id)
   );

   // Handshake FSM. The grant, vector address and irq are captured together
   // on leaving IDLE and then held untouched until the acknowledge, so later
   // mask or pending changes cannot disturb a request already on the wire.
   // INSERVICE blocks further requests until software writes EOI.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IRQ_IDLE;
         irq       <= 1'b0;
         irq_addr  <= VEC_BASE;
         active_id <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
         rr_ptr    <= '0;
`endif
      end else begin
         case (state)
            IRQ_IDLE: begin
               if (arb_valid) begin
                  active_id <= arb_id;
                  irq_addr  <= vec_addr(VEC_BASE, VEC_STRIDE, arb_id);
                  irq       <= 1'b1;
                  state     <= IRQ_ASSERT;
               end
            end
            IRQ_ASSERT: begin
               if (irq_ack) begin
                  irq   <= 1'b0;
                  state <= IRQ_INSERVICE;
`ifdef IRQ_ROUND_ROBIN_EN
                  rr_ptr <= rr_next;
`endif
               end
            end
            IRQ_INSERVICE: begin
               if (eoi_wr) begin
                  state <= IRQ_IDLE;
               end
            end
            default: begin
               irq   <= 1'b0;
               state <= IRQ_IDLE;
            end
         endcase
      end
   end

   // Register read mux, zero-extended to 32 bits; EOI reads as zero
   always_comb begin
      rd = '0;
      case (a)
         REG_PENDING: rd[N_SRC-1:0] = pending;
         REG_MASK:    rd[N_SRC-1:0] = mask;
         REG_STATUS: begin
            rd[STAT_STATE_LSB +: STAT_STATE_W] = state;
            rd[STAT_ID_LSB +: STAT_ID_W]       = active_id;
`ifdef IRQ_ROUND_ROBIN_EN
            rd[STAT_RR_LSB +: STAT_RR_W]       = rr_ptr;
`endif
         end
         default: rd = '0;
      endcase
   end

endmodule

// File: doc/irq_vector_ctrl.md
Name: irq_vector_ctrl

Overview:
Vectored interrupt controller between the factorial units' Done outputs and the mips core's irq/irq_ack/irq_addr interface. It edge-detects completion events, latches them as pending, applies a software mask and selects one source by priority. It then drives a held IRQ/ACK handshake with a vector address. A small memory-mapped register window lets the CPU read status, set the mask and signal end-of-interrupt (EOI).

Parameters:
N_SRC, 4, number of interrupt sources (1..8)
VEC_BASE, 32'h0000_0100, vector address for source 0
VEC_STRIDE, 32'h0000_0010, byte spacing between source vectors

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
src_done  input  N_SRC  level completion flags from the fact_top units
irq_ack  input  1  one-cycle acknowledge from the core
irq  output  1  interrupt request to the core
irq_addr  output  32  vector address of the granted source
we  input  1  register write strobe, already decoded by the address decoder
a  input  2  register select, taken from alu_out[3:2]
wd  input  32  write data
rd  output  32  read data, combinational from registers

Behaviour:
- Reset (rst=0, asynchronous) clears state and outputs:
  - state=IDLE, pending=0, mask=all ones (all sources enabled), done_q=0, active_id=0.
  - irq=0, irq_addr=VEC_BASE.
- Edge detect: done_q<=src_done every cycle. A rise (src_done & ~done_q) sets pending[i].
  - A level held high produces exactly one event.
- Register map (reads return zero-extended values):
  - a=0 PENDING: read pending. Write is W1C.
  - a=1 MASK: read/write, bits [N_SRC-1:0].
  - a=2 STATUS: read {state[1:0] at [9:8], active_id at [2:0]}. Writes ignored.
  - a=3 EOI: a write of any value ends service. Reads return 0.
- Same-cycle conflict: a rise on source i and a W1C of bit i in the same cycle leaves pending[i]=1 (set wins).
- Candidate set: pending & mask. Fixed priority, lowest index wins.
- FSM:
  - IDLE: if the candidate set is non-zero, latch active_id=winner, irq_addr=VEC_BASE+active_id*VEC_STRIDE, irq<=1, go to ASSERT. Otherwise stay.
  - ASSERT: irq stays 1 with active_id/irq_addr frozen, even if the mask or pending bits change. On irq_ack: irq<=0, clear pending[active_id], go to INSERVICE.
  - INSERVICE: irq=0. New events still latch into pending. An EOI write goes to IDLE.
- Ignored inputs:
  - irq_ack in IDLE or INSERVICE.
  - EOI write in IDLE or ASSERT.
- Ack and rise together: irq_ack in ASSERT plus a rise on active_id in the same cycle leaves pending[active_id]=1 (re-arm wins over the clear).
- Latency: src_done sampled high at edge k → pending at k → irq=1 after edge k+1 (2 cycles). After an EOI, the next irq can appear one cycle after returning to IDLE.
- No nesting: at most one interrupt is outstanding.
- Arithmetic: irq_addr computed in 32 bits; overflow wraps modulo 2^32.

Optional Feature:
- Macro: IRQ_ROUND_ROBIN_EN.
- When defined:
  - A rotating priority pointer rr_ptr (reset 0) is added.
  - Arbitration searches from rr_ptr upward, wrapping at N_SRC.
  - On irq_ack, rr_ptr<=(active_id+1) mod N_SRC.
  - STATUS[6:4] reads rr_ptr.
- When undefined: fixed priority, STATUS[6:4]=0, and no rr_ptr flop exists.

Decomposition:
- Shared package irq_pkg holds:
  - state encoding IRQ_IDLE=2'd0, IRQ_ASSERT=2'd1, IRQ_INSERVICE=2'd2;
  - register offsets REG_PENDING=0, REG_MASK=1, REG_STATUS=2, REG_EOI=3;
  - STATUS field bit positions.
- One sub-module, irq_prio_arb: combinational N_SRC-wide arbiter with inputs req and base pointer, outputs valid and grant id. It is reused in both fixed mode (base=0) and round-robin mode.

Test Plan:
- Reset: hold rst=0 with src_done=4'b1111, then release → irq=0, PENDING=0, MASK=4'hF, STATUS=0. Keep src_done high → exactly one event per source (no retrigger).
- Single source: pulse src_done[2] → irq=1 two cycles later with irq_addr=32'h0000_0120. irq_ack → irq=0, PENDING[2]=0, STATUS state=2. EOI write → state=0.
- Simultaneous: sources 1 and 3 rise together → grant id 1 (addr 0x110). After ack+EOI → grant id 3 (addr 0x130).
- Mask: write MASK=4'b1110, pulse src_done[0] → no irq, PENDING=4'b0001. Write MASK=4'hF → irq with addr 0x100.
- Conflicts:
  - W1C of PENDING[1] in the same cycle as a src_done[1] rise → PENDING[1] stays 1.
  - irq_ack while active source 0 re-rises → PENDING[0] stays 1.
  - EOI in IDLE and irq_ack in IDLE → no state change.
- Round-robin (IRQ_ROUND_ROBIN_EN): all four pending at once, each serviced with ack+EOI → grant order 0,1,2,3. A re-raised source 0 while 1–3 are pending is served after 3.
